// File: rtl/port_rr_arbiter_pkg.sv
// Shared types and constants for port_rr_arbiter and its round-robin picker.
//   state_e : output-register FSM state (IDLE = empty, HOLD = full)
//   STATS_W : width of each per-requester grant counter
//   idx_w() : source-index width for N requesters, never below 1
package port_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned STATS_W = 16;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/port_rr_arbiter_rr_pick.sv
// Combinational round-robin picker, reusable by any sharing block.
// Ports:
//   req     : request vector
//   last    : index of the previous winner (search starts at last+1)
//   grant_c : one-hot winner, zero when no request
//   idx_c   : winner index, zero when no request
//   any_c   : at least one request present
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  int unsigned best;
  int unsigned best_d;
  int unsigned d;

  // The winner is the requester with the smallest circular distance past last.
  always_comb begin
    best   = 0;
    best_d = N;
    d      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      d = (i + 2 * N - 1 - 32'(last)) % N;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        best   = i;
      end
    end
    any_c = (best_d != N);
    idx_c = IW'(best);
    for (int unsigned i = 0; i < N; i++) begin
      grant_c[i] = any_c && (i == best);
    end
  end

endmodule

// File: rtl/port_rr_arbiter.sv
// Round-robin arbiter sharing one registered output port among NUM_REQ
// valid/ready requesters; each accepted word is tagged with its source index.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   req_valid/data    : per-requester handshake, data i in [i*DATA_W +: DATA_W]
//   req_ready         : one-hot (or zero) accept, combinational
//   out_valid/data/src: output register contents, out_ready accepts it
//   busy              : mirror of out_valid
// Optional (PORT_RR_ARBITER_STATS_EN): stats_clr input and grant_cnt output,
// one saturating STATS_W-bit capture counter per requester.
module port_rr_arbiter
  import port_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
`ifdef PORT_RR_ARBITER_STATS_EN
  input  logic                       stats_clr,
  output logic [NUM_REQ*STATS_W-1:0] grant_cnt,
`endif
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_src,
  input  logic                       out_ready,
  output logic                       busy
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_src_q, out_src_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               can_load;
  logic               load;
  logic [DATA_W-1:0]  win_data;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req     (req_valid),
    .last    (last_q),
    .grant_c (grant),
    .idx_c   (win_idx),
    .any_c   (win_any)
  );

  // Accept when the register is empty or is being drained this cycle.
  always_comb begin
    can_load  = (state_q == IDLE) || out_ready;
    load      = can_load && win_any;
    req_ready = can_load ? grant : '0;
    win_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state: load wins over pop so back-to-back words stay in HOLD.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load) begin
      state_d     = HOLD;
      last_d      = win_idx;
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_src_d   = win_idx;
    end else if ((state_q == HOLD) && out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = out_valid_q;

`ifdef PORT_RR_ARBITER_STATS_EN
  logic [STATS_W-1:0] cnt_q [NUM_REQ];
  logic [STATS_W-1:0] cnt_d [NUM_REQ];

  // Clear has priority over a simultaneous capture; counters saturate.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (load && grant[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + STATS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!rst_n) cnt_q[i] <= '0;
      else        cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*STATS_W +: STATS_W] = cnt_q[g];
  end
`endif

endmodule
